conv1_scheduler: RTL
====================

Name: conv1_scheduler

Overview:
- Sequences the first convolution layer (227x227x3 input, 11x11x3 kernels, stride 4, 55x55x96 output) onto one shared MAC engine.
- The MAC engine computes CH_PAR output channels per job.
- The scheduler walks every output pixel and channel group and issues one job per (row, col, group).
- It applies ReLU to the returned sums and hands the results to the output buffer writer with backpressure.

Parameters:
- DATA_W, 16: element width, signed two's complement.
- IMG_W, 227: input image width and height.
- K, 11: kernel width and height.
- STRIDE, 4: convolution stride.
- NUM_CH, 96: output channel count.
- CH_PAR, 8: channels per MAC job. NUM_CH must be a multiple of CH_PAR.
- OUT_W, (IMG_W-K)/STRIDE+1 = 55: output width and height. Derived; never overridden independently.

Ports:
- clk, in, 1: clock, rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- start, in, 1: single-cycle pulse that begins a full layer pass.
- busy, out, 1: high from the cycle after an accepted start until the done cycle.
- done, out, 1: one-cycle pulse after the last write is accepted.
- job_valid, out, 1: MAC job request.
- job_ready, in, 1: MAC engine accepts the job.
- job_row, out, 8: input window top row = out_row*STRIDE.
- job_col, out, 8: input window left column = out_col*STRIDE.
- job_grp, out, 4: kernel group index. Kernels grp*CH_PAR .. grp*CH_PAR+CH_PAR-1.
- res_valid, in, 1: MAC result available.
- res_data, in, CH_PAR*DATA_W: raw sums. Lane i is channel grp*CH_PAR+i; lane 0 is in the LSBs.
- wr_valid, out, 1: output write request.
- wr_ready, in, 1: writer accepts.
- wr_row, out, 6: output row.
- wr_col, out, 6: output column.
- wr_grp, out, 4: output group.
- wr_data, out, CH_PAR*DATA_W: ReLU'd results, same lane order as res_data.
- cycle_cnt, out, 32: cycles spent busy in the current or last pass.

Behaviour:
- Reset values: busy, done, job_valid, wr_valid are 0. job_row/col/grp, wr_row/col/grp, wr_data, cycle_cnt are 0. FSM is in IDLE. Reset applies immediately, including mid-pass; no partial state survives it.
- FSM states: IDLE, ISSUE, WAIT, WRITE, DONE.
  - IDLE: start=1 clears counters r=c=g=0, clears cycle_cnt, and moves to ISSUE.
  - ISSUE: job_valid=1 with fields from (r,c,g). On job_valid&&job_ready, go to WAIT. Fields stay stable while job_valid is high.
  - WAIT: on res_valid, capture ReLU(res_data) into wr_data and go to WRITE. res_valid in any other state is ignored.
  - WRITE: wr_valid=1 with wr_row/col/grp = r/c/g. Fields stay stable until wr_ready. On wr_valid&&wr_ready:
    - If this is the last job (r=c=OUT_W-1, g=NUM_CH/CH_PAR-1), go to DONE.
    - Otherwise advance the counters and go to ISSUE.
  - DONE: done=1 for one cycle, busy drops in the same cycle, then go to IDLE.
- Exactly one job outstanding at a time. The next job_valid rises the cycle after the write handshake.
- Iteration order:
  - g increments fastest and wraps to 0 at NUM_CH/CH_PAR, carrying into c.
  - c wraps to 0 at OUT_W, carrying into r.
  - Total jobs = OUT_W*OUT_W*NUM_CH/CH_PAR (36300 by default).
- ReLU is applied per lane. If the lane MSB is 1, the output is 0. Otherwise the lane passes unchanged. 0x8000 maps to 0; 0x7FFF passes.
- start is ignored while busy, including in the DONE cycle. start in the cycle after DONE begins a new pass.
- cycle_cnt:
  - Increments every cycle while busy.
  - Saturates at 0xFFFFFFFF.
  - Holds after done until the next start.
- Minimum cost is 3 cycles per job (ISSUE, WAIT, WRITE) with zero-latency handshakes.
- job_row and job_col never exceed IMG_W-K (216).

Test Plan:
- Small config (IMG_W=19, K=11, STRIDE=4, NUM_CH=16, CH_PAR=8, so OUT_W=3), ready and results immediate, start pulse -> 18 jobs in order (0,0,0),(0,0,1),(0,1,0)…(2,2,1). job_row/col take values 0, 4, 8. done pulses once after the 18th write; busy spans exactly those cycles.
- ReLU lanes: res_data lanes {0x0000, 0x0001, 0x7FFF, 0x8000, 0xFFFF, 0x1234, 0xC000, 0x0100} -> wr_data lanes {0, 1, 0x7FFF, 0, 0, 0x1234, 0, 0x0100}.
- Backpressure: hold job_ready=0 for 5 cycles, then res_valid 7 cycles late, then wr_ready=0 for 4 cycles -> all fields stay stable while stalled, no duplicate or lost handshakes, cycle_cnt grows by the stall cycles.
- Spurious inputs: res_valid during IDLE/ISSUE and start while busy -> no state change. start in the cycle after done -> new pass begins at (0,0,0).
- Reset mid-pass: assert rst_n=0 during WRITE at job 7 -> all outputs 0 immediately. After release with no start, the block stays IDLE. After a new start, the pass restarts at (0,0,0).
- Default config, fast handshakes -> exactly 36300 writes, last one (54,54,11), max job_row = 216, cycle_cnt = 108900 (3 cycles per job).

Source files
------------

// File: rtl/conv1_scheduler.sv
// Layer-1 convolution job scheduler: walks every (row, col, channel group) of the
// output map, issues one MAC job at a time, applies ReLU and forwards results to the writer.
module conv1_scheduler #(
  parameter int DATA_W = 16,
  parameter int IMG_W  = 227,
  parameter int K      = 11,
  parameter int STRIDE = 4,
  parameter int NUM_CH = 96,
  parameter int CH_PAR = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     job_valid,
  input  logic                     job_ready,
  output logic [7:0]               job_row,
  output logic [7:0]               job_col,
  output logic [3:0]               job_grp,
  input  logic                     res_valid,
  input  logic [CH_PAR*DATA_W-1:0] res_data,
  output logic                     wr_valid,
  input  logic                     wr_ready,
  output logic [5:0]               wr_row,
  output logic [5:0]               wr_col,
  output logic [3:0]               wr_grp,
  output logic [CH_PAR*DATA_W-1:0] wr_data,
  output logic [31:0]              cycle_cnt
);

  localparam int OUT_W   = (IMG_W - K) / STRIDE + 1;
  localparam int NUM_GRP = NUM_CH / CH_PAR;

  localparam logic [5:0] LAST_RC  = 6'(OUT_W - 1);
  localparam logic [3:0] LAST_GRP = 4'(NUM_GRP - 1);
  localparam logic [7:0] STRIDE_L = 8'(STRIDE);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]               state_q, state_d;
  logic [5:0]               row_q, row_d;
  logic [5:0]               col_q, col_d;
  logic [3:0]               grp_q, grp_d;
  logic [CH_PAR*DATA_W-1:0] data_q, data_d;
  logic [31:0]              cnt_q, cnt_d;
  logic [CH_PAR*DATA_W-1:0] relu_data;
  logic                     last_job;
  logic                     in_pass;

  // Per-lane ReLU: a set sign bit means a negative sum, which clamps to zero.
  always_comb begin
    relu_data = res_data;
    for (int i = 0; i < CH_PAR; i++) begin
      if (res_data[i*DATA_W + DATA_W - 1]) begin
        relu_data[i*DATA_W +: DATA_W] = '0;
      end
    end
  end

  assign last_job = (row_q == LAST_RC) && (col_q == LAST_RC) && (grp_q == LAST_GRP);
  assign in_pass  = (state_q == S_ISSUE) || (state_q == S_WAIT) || (state_q == S_WRITE);

  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the case infers a latch.
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    grp_d   = grp_q;
    data_d  = data_q;
    cnt_d   = cnt_q;

    if (in_pass && (cnt_q != '1)) begin
      cnt_d = cnt_q + 32'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          row_d   = '0;
          col_d   = '0;
          grp_d   = '0;
          cnt_d   = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (job_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (res_valid) begin
          data_d  = relu_data;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (wr_ready) begin
          if (last_job) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ISSUE;
            // Group is the fastest index, then column, then row.
            if (grp_q == LAST_GRP) begin
              grp_d = '0;
              if (col_q == LAST_RC) begin
                col_d = '0;
                row_d = row_q + 6'd1;
              end else begin
                col_d = col_q + 6'd1;
              end
            end else begin
              grp_d = grp_q + 4'd1;
            end
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      grp_q   <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      // NOTE: non-blocking updates so every register samples the pre-edge value of its peers.
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      grp_q   <= grp_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy      = in_pass;
  assign done      = (state_q == S_DONE);
  assign job_valid = (state_q == S_ISSUE);
  assign wr_valid  = (state_q == S_WRITE);
  assign job_row   = {2'b00, row_q} * STRIDE_L;
  assign job_col   = {2'b00, col_q} * STRIDE_L;
  assign job_grp   = grp_q;
  assign wr_row    = row_q;
  assign wr_col    = col_q;
  assign wr_grp    = grp_q;
  assign wr_data   = data_q;
  assign cycle_cnt = cnt_q;

endmodule
